// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter sharing one external ALU between two requesters: accept -> EXEC -> RESP.
// Response appears two cycles after the accept cycle and is held until rsp_ready; no accept while busy.
module alu_share_ctrl #(
   parameter int WIDTH = 4,
   parameter int SEL_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [SEL_W-1:0] req0_sel,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [SEL_W-1:0] req1_sel,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [SEL_W-1:0] alu_sel,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carry,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_carry
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [SEL_W-1:0] sel;
   } op_t;

   state_t state;
   logic   last_grant;
   logic   cur_id;
   logic   grant;
   logic   accept;
   op_t    grant_op;

   // On contention the requester that did not win last time gets the grant.
   always_comb begin
      grant = req1_valid;
      if (req0_valid && req1_valid) begin
         grant = ~last_grant;
      end
      req0_ready = (state == IDLE) && req0_valid && !grant;
      req1_ready = (state == IDLE) && req1_valid && grant;
      accept     = req0_ready || req1_ready;
      grant_op   = grant ? op_t'{req1_a, req1_b, req1_sel} : op_t'{req0_a, req0_b, req0_sel};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         cur_id     <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_sel    <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_carry  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  alu_a      <= grant_op.a;
                  alu_b      <= grant_op.b;
                  alu_sel    <= grant_op.sel;
                  cur_id     <= grant;
                  last_grant <= grant;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               rsp_result <= alu_result;
               rsp_carry  <= alu_carry;
               rsp_id     <= cur_id;
               rsp_valid  <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU on the alu_* ports.
module tb_alu_share_ctrl;
   localparam int WIDTH = 4;
   localparam int SEL_W = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req0_valid = 1'b0, req1_valid = 1'b0;
   logic             req0_ready, req1_ready;
   logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [SEL_W-1:0] req0_sel = '0, req1_sel = '0;
   logic [WIDTH-1:0] alu_a, alu_b, alu_result;
   logic [SEL_W-1:0] alu_sel;
   logic             alu_carry;
   logic             rsp_valid, rsp_id, rsp_carry;
   logic             rsp_ready = 1'b1;
   logic [WIDTH-1:0] rsp_result;
   logic [WIDTH:0]   alu_full;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_share_ctrl #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_result(alu_result), .alu_carry(alu_carry),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_carry(rsp_carry)
   );

   // External ALU: bit WIDTH of alu_full is carry for ADD and borrow for SUB.
   always_comb begin
      alu_full = '0;
      case (alu_sel)
         2'd0: alu_full = {1'b0, alu_a} + {1'b0, alu_b};
         2'd1: alu_full = {1'b0, alu_a} - {1'b0, alu_b};
         2'd2: alu_full = {1'b0, alu_a & alu_b};
         default: alu_full = {1'b0, alu_a | alu_b};
      endcase
      alu_result = alu_full[WIDTH-1:0];
      alu_carry  = alu_full[WIDTH];
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   // Single-requester op with rsp_ready held high; checks exact cycle timing.
   task automatic op1(input int r, input int a, input int b, input int sel,
                      input int res, input int cy);
      logic [WIDTH-1:0] va, vb;
      logic [SEL_W-1:0] vs;
      va = a[WIDTH-1:0];
      vb = b[WIDTH-1:0];
      vs = sel[SEL_W-1:0];
      @(negedge clk);
      if (r == 0) begin
         req0_valid = 1'b1; req0_a = va; req0_b = vb; req0_sel = vs;
      end else begin
         req1_valid = 1'b1; req1_a = va; req1_b = vb; req1_sel = vs;
      end
      #1;
      chk("op_rdy0", req0_ready, r == 0);
      chk("op_rdy1", req1_ready, r == 1);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      chk("exec_alu_a", alu_a, a);
      chk("exec_alu_b", alu_b, b);
      chk("exec_alu_sel", alu_sel, sel);
      chk("exec_rdy", req0_ready | req1_ready, 0);
      chk("exec_rsp_valid", rsp_valid, 0);
      @(negedge clk);
      #1;
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, r);
      chk("rsp_result", rsp_result, res);
      chk("rsp_carry", rsp_carry, cy);
      @(negedge clk);
      #1;
      chk("rsp_drop", rsp_valid, 0);
   endtask

   initial begin
      int extra;
      do_reset();
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_carry", rsp_carry, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_sel", alu_sel, 0);

      op1(0, 4'b0011, 4'b0101, 0, 4'b1000, 0);
      op1(1, 4'b1000, 4'b0010, 1, 4'b0110, 0);
      op1(1, 4'b1100, 4'b1010, 2, 4'b1000, 0);

      // Both requesters valid continuously: ids must alternate starting with 0.
      do_reset();
      rsp_ready = 1'b1;
      req0_a = 4'b1001; req0_b = 4'b0110; req0_sel = 2'd3;
      req1_a = 4'b1111; req1_b = 4'b0001; req1_sel = 2'd0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("alt_rdy0", req0_ready, (k % 2) == 0);
         chk("alt_rdy1", req1_ready, (k % 2) == 1);
         chk("alt_both", req0_ready & req1_ready, 0);
         @(negedge clk); #1;
         chk("alt_exec_rdy", req0_ready | req1_ready, 0);
         @(negedge clk); #1;
         chk("alt_rsp_valid", rsp_valid, 1);
         chk("alt_rsp_id", rsp_id, k % 2);
         chk("alt_rsp_result", rsp_result, ((k % 2) == 0) ? 15 : 0);
         chk("alt_rsp_carry", rsp_carry, k % 2);
         chk("alt_resp_rdy", req0_ready | req1_ready, 0);
         @(negedge clk); #1;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      // Backpressure: response held for 5 cycles with new requests pending.
      rsp_ready = 1'b0;
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_sel = 2'd0;
      #1;
      chk("bp_rdy0", req0_ready, 1);
      @(negedge clk);
      req0_valid = 1'b0;
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd2; req0_sel = 2'd1;
      req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd3; req1_sel = 2'd3;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rsp_id", rsp_id, 0);
         chk("bp_rsp_result", rsp_result, 2);
         chk("bp_rdy", req0_ready | req1_ready, 0);
         @(negedge clk); #1;
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_hs_rdy", req0_ready | req1_ready, 0);
      @(negedge clk); #1;
      chk("bp_after_valid", rsp_valid, 0);
      chk("bp_next_rdy1", req1_ready, 1);
      chk("bp_next_rdy0", req0_ready, 0);
      req0_valid = 1'b0;
      @(negedge clk);
      req1_valid = 1'b0;
      #1;
      chk("bp_next_alu_a", alu_a, 5);
      @(negedge clk); #1;
      chk("bp_next_id", rsp_id, 1);
      chk("bp_next_result", rsp_result, 7);
      @(negedge clk); #1;

      // Reset pulse during EXEC of a req0 op discards it and restores the pointer.
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 4'd6; req0_b = 4'd3; req0_sel = 2'd0;
      @(negedge clk);
      req0_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rx_exec_alu_a", alu_a, 6);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rx_rsp_valid", rsp_valid, 0);
      chk("rx_alu_a", alu_a, 0);
      chk("rx_alu_b", alu_b, 0);
      chk("rx_rsp_result", rsp_result, 0);
      @(negedge clk); #1;
      chk("rx_no_rsp", rsp_valid, 0);
      req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd7; req0_sel = 2'd2;
      req1_valid = 1'b1;
      #1;
      chk("rx_rdy0", req0_ready, 1);
      chk("rx_rdy1", req1_ready, 0);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk); #1;
      chk("rx_result", rsp_result, 2);
      chk("rx_id", rsp_id, 0);
      @(negedge clk); #1;

      // req0 pulsed while in RESP must never be accepted.
      rsp_ready = 1'b0;
      @(negedge clk);
      req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd9; req1_sel = 2'd1;
      @(negedge clk);
      req1_valid = 1'b0;
      @(negedge clk);
      req0_valid = 1'b1;
      #1;
      chk("pulse_rdy0", req0_ready, 0);
      @(negedge clk);
      req0_valid = 1'b0;
      rsp_ready = 1'b1;
      #1;
      chk("pulse_rsp_valid", rsp_valid, 1);
      chk("pulse_rsp_id", rsp_id, 1);
      chk("pulse_result", rsp_result, 10);
      chk("pulse_borrow", rsp_carry, 1);
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         extra += int'(rsp_valid);
      end
      chk("pulse_extra_rsp", extra, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
